// File: rtl/sdm_pkg.sv
// Shared definitions for the multi-channel sigma-delta DAC: mode encodings
// and width helpers used to size the integrators and the tick counter.
package sdm_pkg;

  localparam logic MODE_ORDER1 = 1'b0;
  localparam logic MODE_ORDER2 = 1'b1;

  // Stored width of the second-order integrators.
  function automatic int unsigned integ_width(input int unsigned width,
                                              input int unsigned guard);
    return width + guard;
  endfunction

  // Arithmetic width for integrator updates: two spare bits so the sum of an
  // integrator and two WIDTH-bit terms can never wrap before saturation.
  function automatic int unsigned integ_calc_width(input int unsigned width,
                                                   input int unsigned guard);
    return width + guard + 2;
  endfunction

  function automatic int unsigned tick_cnt_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/sdm_channel.sv
// One sigma-delta modulator channel: first-order accumulator/carry or
// second-order saturating double integrator, stepped on each shared tick.
module sdm_channel
  import sdm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick,
  input  logic             mode,
  input  logic [WIDTH-1:0] sample,
  output logic             dout
);

  localparam int IW = int'(integ_width(WIDTH, GUARD));
  localparam int SW = int'(integ_calc_width(WIDTH, GUARD));

  localparam logic signed [SW-1:0] HALF   = SW'(longint'(1) <<< (WIDTH - 1));
  localparam logic signed [SW-1:0] SAT_HI = SW'((longint'(1) <<< (IW - 1)) - longint'(1));
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  logic [WIDTH-1:0]     acc_q, acc_d;
  logic signed [IW-1:0] i1_q, i1_d;
  logic signed [IW-1:0] i2_q, i2_d;
  logic                 dout_q, dout_d;

  logic [WIDTH:0]       sum1;
  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] y;
  logic signed [SW-1:0] i1_sum;
  logic signed [SW-1:0] i2_sum;
  logic signed [IW-1:0] i1_new;
  logic signed [IW-1:0] i2_new;

  function automatic logic signed [IW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > SAT_HI) return IW'(SAT_HI);
    if (v < SAT_LO) return IW'(SAT_LO);
    return IW'(v);
  endfunction

  always_comb begin
    acc_d  = acc_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    dout_d = dout_q;

    // Offset-binary conversion is just an MSB flip of the two's-complement sample.
    sum1   = {1'b0, acc_q} + {1'b0, ~sample[WIDTH-1], sample[WIDTH-2:0]};

    x_ext  = SW'($signed(sample));
    y      = dout_q ? HALF : -HALF;
    i1_sum = SW'(i1_q) + x_ext - y;
    i1_new = clamp(i1_sum);
    i2_sum = SW'(i2_q) + SW'(i1_new) - y;
    i2_new = clamp(i2_sum);

    if (!en) begin
      acc_d  = '0;
      i1_d   = '0;
      i2_d   = '0;
      dout_d = 1'b0;
    end else if (tick) begin
      if (mode == MODE_ORDER2) begin
        i1_d   = i1_new;
        i2_d   = i2_new;
        dout_d = ~i2_new[IW-1];
      end else begin
        acc_d  = sum1[WIDTH-1:0];
        dout_d = sum1[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel sigma-delta DAC: tick divider, pending/active frame double
// buffer with valid/ready intake, and one sdm_channel per channel.
module sigma_delta_dac_mc
  import sdm_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int GUARD    = 4,
  parameter int DIV      = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      order2,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS-1:0]       dout,
  output logic                      tick_o
);

  localparam int FW = CHANNELS * WIDTH;
  localparam int CW = int'(tick_cnt_width(DIV));
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  logic [FW-1:0] active_q, active_d;
  logic          mode_q, mode_d;
  logic          tick_o_q, tick_o_d;

  logic tick;
  logic accept;
  logic transfer;

  always_comb begin
    tick     = en && (cnt_q == CNT_LAST);
    accept   = din_valid && !pending_full_q;
    transfer = tick && pending_full_q;

    cnt_d          = (!en || tick) ? '0 : cnt_q + CW'(1);
    pending_d      = accept ? din : pending_q;
    pending_full_d = accept || (pending_full_q && !transfer);
    active_d       = transfer ? pending_q : active_q;
    mode_d         = en ? mode_q : order2;
    tick_o_d       = tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= '0;
      mode_q         <= order2;
      tick_o_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      mode_q         <= mode_d;
      tick_o_q       <= tick_o_d;
    end
  end

  assign din_ready = ~pending_full_q;
  assign tick_o    = tick_o_q;

  // Channels see active_d so a frame transferred on a tick is modulated on that same edge.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sdm_channel #(
      .WIDTH (WIDTH),
      .GUARD (GUARD)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .tick   (tick),
      .mode   (mode_q),
      .sample (active_d[c*WIDTH +: WIDTH]),
      .dout   (dout[c])
    );
  end

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
// Randomised scoreboard bench for sigma_delta_dac_mc (2 channels, 16 bit, DIV=4).
module tb_sigma_delta_dac_mc;

  localparam int CH  = 2;
  localparam int W   = 16;
  localparam int G   = 4;
  localparam int DIV = 4;
  localparam int FW  = CH * W;
  localparam longint H   = longint'(1) << (W - 1);
  localparam longint SAT = (longint'(1) << (W + G - 1)) - 1;

  logic          clk;
  logic          reset;
  logic          en;
  logic          order2;
  logic          din_valid;
  logic          din_ready;
  logic [FW-1:0] din;
  logic [CH-1:0] dout;
  logic          tick_o;

  sigma_delta_dac_mc #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .GUARD    (G),
    .DIV      (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .order2    (order2),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .dout      (dout),
    .tick_o    (tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic ready;
    logic tick;
    logic idle;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [CH-1:0] tick_q[$];

  // Reference model state, kept in plain integer arithmetic.
  bit            m_mode;
  bit            m_pf;
  logic [FW-1:0] m_pend;
  logic [FW-1:0] m_act;
  int            m_phase;
  longint        m_acc[CH];
  longint        m_i1[CH];
  longint        m_i2[CH];
  bit            m_d[CH];

  bit win_arm = 1'b0;
  int win_n, win_target, win_ones0, win_ones1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic longint clampl(input longint v);
    if (v > SAT) return SAT;
    if (v < -SAT) return -SAT;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      m_acc[c] = 0;
      m_i1[c]  = 0;
      m_i2[c]  = 0;
      m_d[c]   = 1'b0;
    end
    m_phase = 0;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit rst_i, input bit en_i, input bit o2_i,
                            input bit v_i, input logic [FW-1:0] d_i, output bit acc_o);
    bit            tick;
    logic [W-1:0]  s;
    longint        x, y;
    logic [CH-1:0] dv;
    acc_o = 1'b0;
    if (rst_i) begin
      m_mode = o2_i;
      m_pf   = 1'b0;
      m_pend = '0;
      m_act  = '0;
      model_clear();
      cyc_q.push_back('{ready: 1'b1, tick: 1'b0, idle: 1'b1});
      return;
    end
    acc_o = v_i && !m_pf;
    tick  = en_i && (m_phase == DIV - 1);
    if (tick && m_pf) begin
      m_act = m_pend;
      m_pf  = 1'b0;
    end
    if (acc_o) begin
      m_pend = d_i;
      m_pf   = 1'b1;
    end
    if (!en_i) begin
      model_clear();
      m_mode = o2_i;
    end else begin
      m_phase = (m_phase + 1) % DIV;
      if (tick) begin
        for (int c = 0; c < CH; c++) begin
          s = m_act[c*W +: W];
          x = longint'($signed(s));
          if (!m_mode) begin
            m_acc[c] = m_acc[c] + x + H;
            m_d[c]   = (m_acc[c] >= 2 * H);
            if (m_d[c]) m_acc[c] = m_acc[c] - 2 * H;
          end else begin
            y       = m_d[c] ? H : -H;
            m_i1[c] = clampl(m_i1[c] + x - y);
            m_i2[c] = clampl(m_i2[c] + m_i1[c] - y);
            m_d[c]  = (m_i2[c] >= 0);
          end
          dv[c] = m_d[c];
        end
        tick_q.push_back(dv);
      end
    end
    cyc_q.push_back('{ready: !m_pf, tick: tick, idle: !en_i});
  endtask

  task automatic step(input bit rst_i, input bit en_i, input bit o2_i,
                      input bit v_i, input logic [FW-1:0] d_i, output bit acc_o);
    reset     = rst_i;
    en        = en_i;
    order2    = o2_i;
    din_valid = v_i;
    din       = d_i;
    model_step(rst_i, en_i, o2_i, v_i, d_i, acc_o);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle handshake/tick checks, per-tick dout scoreboard.
  always @(negedge clk) begin
    cyc_t          e;
    logic [CH-1:0] td;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("din_ready", 32'(din_ready), 32'(e.ready));
      chk("tick_o", 32'(tick_o), 32'(e.tick));
      if (e.idle) chk("dout_idle", 32'(dout), 32'd0);
    end
    if (tick_o === 1'b1) begin
      if (tick_q.size() == 0) begin
        chk("tick_unexpected", 32'd1, 32'd0);
      end else begin
        td = tick_q.pop_front();
        chk("dout", 32'(dout), 32'(td));
      end
      if (win_arm && win_n < win_target) begin
        win_n++;
        win_ones0 += int'(dout[0]);
        win_ones1 += int'(dout[1]);
      end
    end
  end

  // Load a frame with en low (restarting integrators, latching mode), then
  // count ones per channel over n ticks.
  task automatic window(input string name, input bit o2_i, input logic [FW-1:0] frame,
                        input int n, input int lo0, input int hi0, input int lo1, input int hi1);
    bit a;
    int guard;
    guard = 0;
    while (m_pf && guard < 4 * DIV) begin
      step(1'b0, 1'b1, o2_i, 1'b0, frame, a);
      guard++;
    end
    step(1'b0, 1'b0, o2_i, 1'b1, frame, a);
    win_n      = 0;
    win_ones0  = 0;
    win_ones1  = 0;
    win_target = n;
    win_arm    = 1'b1;
    guard      = 0;
    while (win_n < n && guard < n * DIV + 40) begin
      step(1'b0, 1'b1, o2_i, 1'b0, frame, a);
      guard++;
    end
    win_arm = 1'b0;
    chk({name, "_ticks"}, 32'(win_n), 32'(n));
    chk_rng({name, "_ones0"}, win_ones0, lo0, hi0);
    chk_rng({name, "_ones1"}, win_ones1, lo1, hi1);
  endtask

  task automatic rand_phase(input int n, input bit b2b, input bit allow_dis);
    bit            a;
    bit            v;
    bit            e;
    logic [FW-1:0] cur;
    cur = FW'($urandom);
    for (int i = 0; i < n; i++) begin
      v = b2b ? 1'b1 : 1'($urandom_range(0, 1));
      e = !(allow_dis && ($urandom_range(0, 39) == 0));
      step(1'b0, e, 1'($urandom_range(0, 1)), v, cur, a);
      if (a) cur = FW'($urandom);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, a);

    window("o1_zero", 1'b0, '0, 64, 32, 32, 32, 32);
    rand_phase(600, 1'b0, 1'b0);
    rand_phase(200, 1'b1, 1'b0);
    window("o1_extreme", 1'b0, {16'h8000, 16'h7fff}, 4096, 4095, 4095, 0, 0);

    // Mid-stream reset with a pending frame held.
    for (int i = 0; i < 4 * DIV && m_pf; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, a);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, a);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, a);
    window("post_reset", 1'b0, '0, 64, 32, 32, 32, 32);

    rand_phase(300, 1'b0, 1'b0);
    window("o2_zero", 1'b1, '0, 1024, 510, 514, 510, 514);
    rand_phase(300, 1'b0, 1'b0);
    window("o2_30000", 1'b1, {16'(-16'sd30000), 16'(16'sd30000)}, 4096, 3903, 3943, 153, 193);
    rand_phase(400, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, a);
    @(negedge clk);
    chk("tick_q_drained", 32'(tick_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_delta_dac_mc.md
SIGMA_DELTA_DAC_MC -- requirements
Module: sigma_delta_dac_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent modulator channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 16: signed input sample width per channel (8..24).
REQ-003 SHALL have parameter GUARD, default 4: extra integrator bits above WIDTH for second-order mode.
REQ-004 SHALL have parameter DIV, default 1: modulator update divider; one update (tick) every DIV clocks (1..256).
REQ-005 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  in  1  modulator enable; 0 clears integrators and tick counter.
REQ-008 SHALL have port order2  in  1  0 = first-order, 1 = second-order; sampled only while en = 0 or reset.
REQ-009 SHALL have port din_valid  in  1  input sample frame valid.
REQ-010 SHALL have port din_ready  out  1  pending buffer empty, frame accepted when valid & ready.
REQ-011 SHALL have port din  in  CHANNELS*WIDTH  signed two's-complement samples, channel 0 in LSBs.
REQ-012 SHALL have port dout  out  CHANNELS  registered 1-bit density outputs, one per channel.
REQ-013 SHALL have port tick_o  out  1  registered pulse, high the cycle after each modulator update.

Function
REQ-014 SHALL count a tick counter 0..DIV-1 while en = 1; tick asserted when counter = DIV-1 (every cycle when DIV = 1), counter wraps to 0.
REQ-015 SHALL hold two frame registers: pending (with full flag) and active; din_ready = ~pending_full.
REQ-016 On accept (din_valid & din_ready) SHALL load pending and set pending_full; din held when not ready; no accept lost or duplicated.
REQ-017 On tick with pending_full SHALL copy pending to active and clear pending_full; accept and transfer in the same cycle SHALL leave the newly accepted frame in pending with pending_full = 1.
REQ-018 Modulator step on a tick SHALL use the active value as updated at that edge (a transferred frame affects dout one clock after the tick).
REQ-019 Without a new frame SHALL keep modulating the last active value (hold, no underflow error).
REQ-020 First order: u = din + 2^(WIDTH-1) unsigned; acc (WIDTH bits) + u computed in WIDTH+1 bits; dout = carry, acc = low WIDTH bits.
REQ-021 Second order: y = +2^(WIDTH-1) if previous dout = 1 else -2^(WIDTH-1); i1 += x - y; i2 += i1 - y; dout = (i2 >= 0); i1, i2 signed WIDTH+GUARD bits.
REQ-022 Second-order integrators SHALL saturate at ±(2^(WIDTH+GUARD-1)-1), never wrap.
REQ-023 When en = 0 SHALL clear acc, i1, i2, tick counter, dout = 0, tick_o = 0; handshake and pending/active registers remain operational.
REQ-024 order2 SHALL be latched into an internal mode register only when en = 0 or reset; changes while en = 1 ignored.
REQ-025 All channels SHALL step on the same tick; channels fully independent otherwise.

Reset
REQ-026 Reset SHALL set dout = 0, tick_o = 0, din_ready = 1, pending_full = 0, pending = active = 0, all integrators and tick counter 0, mode = order2.
REQ-027 Reset mid-operation SHALL discard pending and active frames; first post-reset tick modulates zero input.

Structure
REQ-028 Shared package sdm_pkg SHALL hold mode encoding constants (MODE_ORDER1, MODE_ORDER2) and width helper functions for integrator size.
REQ-029 Per-channel modulator SHALL be sub-module sdm_channel (one instance per channel via generate); top holds tick counter, handshake and frame registers.

Verification
REQ-030 WIDTH=16, DIV=1, order1, din=0 constant -> dout sequence 0,1,0,1,... from first tick; 50% density.
REQ-031 order1, din=32767 -> 65535 ones per 65536 ticks; din=-32768 -> dout stays 0 for 65536 ticks.
REQ-032 DIV=4, two frames offered back-to-back with no tick between -> first accepted, din_ready low until next tick, second accepted on/after that tick, tick_o every 4th cycle.
REQ-033 order2, din=0 for 1024 ticks -> ones count 512 ±2; din=+30000 for 4096 ticks -> no integrator wrap (saturation flag/checker), density 0.9578 ±0.005.
REQ-034 Reset asserted mid-stream with pending_full = 1 -> next cycle din_ready = 1, dout = 0, then din=0 behaviour as REQ-030.
REQ-035 order2 toggled while en = 1 -> mode unchanged; after en low one cycle and high again -> new mode in effect, integrators restart from 0.
